// File: rtl/fpadd_issue.sv
// Issue/capture stage around the combinational fpadd: registers one operation,
// holds it on the adder for HOLD_CYCLES, then presents the captured result.
module fpadd_issue #(
   parameter int unsigned HOLD_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_op1,
   input  logic [63:0] in_op2,
   input  logic [2:0]  in_rm,
   input  logic [2:0]  in_op_type,
   input  logic [1:0]  in_P,
   input  logic        in_OvEn,
   input  logic        in_UnEn,
   output logic [63:0] op1,
   output logic [63:0] op2,
   output logic [2:0]  rm,
   output logic [2:0]  op_type,
   output logic [1:0]  P,
   output logic        OvEn,
   output logic        UnEn,
   input  logic [63:0] AS_Result,
   input  logic [4:0]  Flags,
   input  logic        Denorm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_result,
   output logic [4:0]  out_flags,
   output logic        out_denorm,
   output logic [4:0]  acc_flags,
   input  logic        flag_clr,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   localparam logic [3:0] CNT_INIT = 4'(HOLD_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [63:0] op1_q, op1_d, op2_q, op2_d;
   logic [2:0]  rm_q, rm_d, op_type_q, op_type_d;
   logic [1:0]  p_q, p_d;
   logic        oven_q, oven_d, unen_q, unen_d;
   logic [63:0] out_result_q, out_result_d;
   logic [4:0]  out_flags_q, out_flags_d;
   logic        out_denorm_q, out_denorm_d;
   logic        out_valid_q, out_valid_d;
   logic [4:0]  acc_flags_q, acc_flags_d;
   logic        accept, capture;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      op1_d        = op1_q;
      op2_d        = op2_q;
      rm_d         = rm_q;
      op_type_d    = op_type_q;
      p_d          = p_q;
      oven_d       = oven_q;
      unen_d       = unen_q;
      out_result_d = out_result_q;
      out_flags_d  = out_flags_q;
      out_denorm_d = out_denorm_q;
      out_valid_d  = out_valid_q;
      in_ready     = 1'b0;
      accept       = 1'b0;
      capture      = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            accept   = in_valid;
         end
         EXEC: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               capture = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            in_ready = out_ready;
            if (out_ready) begin
               out_valid_d = 1'b0;
               accept      = in_valid;
               if (!in_valid) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         op1_d     = in_op1;
         op2_d     = in_op2;
         rm_d      = in_rm;
         op_type_d = in_op_type;
         p_d       = in_P;
         oven_d    = in_OvEn;
         unen_d    = in_UnEn;
         cnt_d     = CNT_INIT;
         state_d   = EXEC;
      end

      if (capture) begin
         out_result_d = AS_Result;
         out_flags_d  = Flags;
         out_denorm_d = Denorm;
         out_valid_d  = 1'b1;
      end

      // Clear applies before the OR so a colliding capture keeps its own flags.
      acc_flags_d = flag_clr ? '0 : acc_flags_q;
      if (capture) acc_flags_d = acc_flags_d | Flags;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         op1_q        <= '0;
         op2_q        <= '0;
         rm_q         <= '0;
         op_type_q    <= '0;
         p_q          <= '0;
         oven_q       <= 1'b0;
         unen_q       <= 1'b0;
         out_result_q <= '0;
         out_flags_q  <= '0;
         out_denorm_q <= 1'b0;
         out_valid_q  <= 1'b0;
         acc_flags_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         op1_q        <= op1_d;
         op2_q        <= op2_d;
         rm_q         <= rm_d;
         op_type_q    <= op_type_d;
         p_q          <= p_d;
         oven_q       <= oven_d;
         unen_q       <= unen_d;
         out_result_q <= out_result_d;
         out_flags_q  <= out_flags_d;
         out_denorm_q <= out_denorm_d;
         out_valid_q  <= out_valid_d;
         acc_flags_q  <= acc_flags_d;
      end
   end

   assign op1        = op1_q;
   assign op2        = op2_q;
   assign rm         = rm_q;
   assign op_type    = op_type_q;
   assign P          = p_q;
   assign OvEn       = oven_q;
   assign UnEn       = unen_q;
   assign out_result = out_result_q;
   assign out_flags  = out_flags_q;
   assign out_denorm = out_denorm_q;
   assign out_valid  = out_valid_q;
   assign acc_flags  = acc_flags_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fpadd_issue.sv
// Bench for fpadd_issue: a table-driven fpadd stand-in feeds two instances
// (HOLD_CYCLES=2 directed, HOLD_CYCLES=1 streaming); results are scoreboarded.
module tb_fpadd_issue;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;
   int unsigned nvec = 0;
   int unsigned nerr = 0;
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [63:0] res;
      logic [4:0]  fl;
      logic        den;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

   // ---------------- instance A, HOLD_CYCLES = 2 ----------------
   logic        in_valid, in_ready;
   logic [63:0] in_op1, in_op2;
   logic [2:0]  in_rm, in_op_type;
   logic [1:0]  in_P;
   logic        in_OvEn, in_UnEn;
   logic [63:0] op1, op2;
   logic [2:0]  rm, op_type;
   logic [1:0]  P;
   logic        OvEn, UnEn;
   logic [63:0] AS_Result;
   logic [4:0]  Flags;
   logic        Denorm;
   logic        out_valid, out_ready;
   logic [63:0] out_result;
   logic [4:0]  out_flags;
   logic        out_denorm;
   logic [4:0]  acc_flags;
   logic        flag_clr, busy;

   fpadd_issue #(.HOLD_CYCLES(2)) dut_a (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op1(in_op1), .in_op2(in_op2), .in_rm(in_rm), .in_op_type(in_op_type),
      .in_P(in_P), .in_OvEn(in_OvEn), .in_UnEn(in_UnEn),
      .op1(op1), .op2(op2), .rm(rm), .op_type(op_type), .P(P), .OvEn(OvEn), .UnEn(UnEn),
      .AS_Result(AS_Result), .Flags(Flags), .Denorm(Denorm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_flags(out_flags), .out_denorm(out_denorm),
      .acc_flags(acc_flags), .flag_clr(flag_clr), .busy(busy)
   );

   // ---------------- instance B, HOLD_CYCLES = 1 ----------------
   logic        s_in_valid, s_in_ready;
   logic [63:0] s_in_op1, s_in_op2;
   logic [2:0]  s_in_rm, s_in_op_type;
   logic [1:0]  s_in_P;
   logic        s_in_OvEn, s_in_UnEn;
   logic [63:0] s_op1, s_op2;
   logic [2:0]  s_rm, s_op_type;
   logic [1:0]  s_P;
   logic        s_OvEn, s_UnEn;
   logic [63:0] s_AS_Result;
   logic [4:0]  s_Flags;
   logic        s_Denorm;
   logic        s_out_valid, s_out_ready;
   logic [63:0] s_out_result;
   logic [4:0]  s_out_flags;
   logic        s_out_denorm;
   logic [4:0]  s_acc_flags;
   logic        s_flag_clr, s_busy;

   fpadd_issue #(.HOLD_CYCLES(1)) dut_b (
      .clk(clk), .reset_n(reset_n),
      .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_op1(s_in_op1), .in_op2(s_in_op2), .in_rm(s_in_rm), .in_op_type(s_in_op_type),
      .in_P(s_in_P), .in_OvEn(s_in_OvEn), .in_UnEn(s_in_UnEn),
      .op1(s_op1), .op2(s_op2), .rm(s_rm), .op_type(s_op_type), .P(s_P),
      .OvEn(s_OvEn), .UnEn(s_UnEn),
      .AS_Result(s_AS_Result), .Flags(s_Flags), .Denorm(s_Denorm),
      .out_valid(s_out_valid), .out_ready(s_out_ready),
      .out_result(s_out_result), .out_flags(s_out_flags), .out_denorm(s_out_denorm),
      .acc_flags(s_acc_flags), .flag_clr(s_flag_clr), .busy(s_busy)
   );

   // fpadd stand-in: known double-precision sums, anything else is garbage.
   function automatic logic [69:0] fp_tab(input logic [63:0] a, input logic [63:0] b);
      case ({a, b})
         {64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000}: fp_tab = {1'b0, 5'h00, 64'h4000_0000_0000_0000};
         {64'h3FF0_0000_0000_0000, 64'h3C30_0000_0000_0000}: fp_tab = {1'b0, 5'h01, 64'h3FF0_0000_0000_0000};
         {64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000}: fp_tab = {1'b0, 5'h00, 64'h4010_0000_0000_0000};
         {64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000}: fp_tab = {1'b0, 5'h00, 64'h4008_0000_0000_0000};
         {64'h3FE0_0000_0000_0000, 64'h3FE0_0000_0000_0000}: fp_tab = {1'b0, 5'h00, 64'h3FF0_0000_0000_0000};
         {64'h4010_0000_0000_0000, 64'h4010_0000_0000_0000}: fp_tab = {1'b0, 5'h00, 64'h4020_0000_0000_0000};
         {64'h4008_0000_0000_0000, 64'h3FF0_0000_0000_0000}: fp_tab = {1'b0, 5'h00, 64'h4010_0000_0000_0000};
         {64'h3FF0_0000_0000_0000, 64'hBFF0_0000_0000_0000}: fp_tab = {1'b0, 5'h00, 64'h0000_0000_0000_0000};
         {64'h3FF8_0000_0000_0000, 64'h3FE0_0000_0000_0000}: fp_tab = {1'b0, 5'h00, 64'h4000_0000_0000_0000};
         {64'h0008_0000_0000_0000, 64'h0008_0000_0000_0000}: fp_tab = {1'b1, 5'h00, 64'h0010_0000_0000_0000};
         {64'h7FF0_0000_0000_0000, 64'hFFF0_0000_0000_0000}: fp_tab = {1'b0, 5'h10, 64'h7FF8_0000_0000_0000};
         default:                                            fp_tab = {1'b1, 5'h1F, 64'hBAD0_BAD0_BAD0_BAD0};
      endcase
   endfunction

   // A's stand-in only settles once its inputs have been stable for 2 cycles.
   logic [63:0] last1 = '0;
   logic [63:0] last2 = '0;
   int unsigned age_q = 0;
   int unsigned age_now;
   assign age_now = (op1 == last1 && op2 == last2) ? age_q + 1 : 1;
   always @(posedge clk) begin
      last1 <= op1;
      last2 <= op2;
      age_q <= (age_now > 100) ? 100 : age_now;
   end
   assign {Denorm, Flags, AS_Result} = (age_now >= 2) ? fp_tab(op1, op2)
                                      : {1'b1, 5'h1F, 64'hBAD0_BAD0_BAD0_BAD0};
   assign {s_Denorm, s_Flags, s_AS_Result} = fp_tab(s_op1, s_op2);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitors
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         if (qa.size() == 0) begin
            chk("a_unexpected_result", out_result, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            exp_t e;
            e = qa.pop_front();
            chk("a_result", out_result, e.res);
            chk("a_flags", 64'(out_flags), 64'(e.fl));
            chk("a_denorm", 64'(out_denorm), 64'(e.den));
         end
      end
   end

   int unsigned nb = 0;
   int unsigned last_b_cyc = 0;
   always @(negedge clk) begin
      if (reset_n && s_out_valid && s_out_ready) begin
         if (qb.size() == 0) begin
            chk("b_unexpected_result", s_out_result, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            exp_t e;
            e = qb.pop_front();
            chk("b_result", s_out_result, e.res);
            chk("b_flags", 64'(s_out_flags), 64'(e.fl));
         end
         if (nb > 0) chk("b_gap", 64'(cyc - last_b_cyc), 64'd2);
         last_b_cyc = cyc;
         nb++;
      end
   end

   task automatic issue_a(input logic [63:0] a, input logic [63:0] b,
                          input logic [1:0] en, input exp_t e);
      int unsigned n = 0;
      bit acc = 1'b0;
      in_op1 = a;
      in_op2 = b;
      {in_OvEn, in_UnEn} = en;
      in_valid = 1'b1;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         n++;
      end
      if (acc) qa.push_back(e);
      #1 in_valid = 1'b0;
      chk("a_accept", 64'(acc), 64'd1);
   endtask

   task automatic wait_valid_a();
      int unsigned n = 0;
      @(negedge clk);
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("a_valid_timeout", 64'(out_valid), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   logic [63:0] vb_a [8];
   logic [63:0] vb_b [8];
   logic [63:0] vb_r [8];

   initial begin
      reset_n = 1'b0;
      in_valid = 1'b1; in_op1 = 64'h3FF0_0000_0000_0000; in_op2 = 64'h3FF0_0000_0000_0000;
      in_rm = '0; in_op_type = '0; in_P = '0; in_OvEn = 1'b0; in_UnEn = 1'b0;
      out_ready = 1'b1; flag_clr = 1'b0;
      s_in_valid = 1'b0; s_in_op1 = '0; s_in_op2 = '0; s_in_rm = '0; s_in_op_type = '0;
      s_in_P = '0; s_in_OvEn = 1'b0; s_in_UnEn = 1'b0; s_out_ready = 1'b1; s_flag_clr = 1'b0;

      // Reset with in_valid held high
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_result", out_result, 64'd0);
      chk("rst_out_misc", 64'({out_flags, out_denorm, acc_flags, busy}), 64'd0);
      chk("rst_ops", op1 | op2, 64'd0);
      chk("rst_ctrl", 64'({rm, op_type, P, OvEn, UnEn}), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1 reset_n = 1'b1; in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Latency: 1.0 + 1.0
      issue_a(64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 2'b00,
              '{64'h4000_0000_0000_0000, 5'h00, 1'b0});
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk("lat_out_valid", 64'(out_valid), 64'(k == 3));
         chk("lat_busy", 64'(busy), 64'd1);
         if (k == 1) chk("lat_adder_in", op1, 64'h3FF0_0000_0000_0000);
         if (k == 3) chk("lat_result", out_result, 64'h4000_0000_0000_0000);
      end
      @(negedge clk);
      chk("lat_idle_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;

      // Backpressure: 1.0 + 2.0 held, next op 2.0 + 2.0 waiting
      out_ready = 1'b0;
      issue_a(64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 2'b11,
              '{64'h4008_0000_0000_0000, 5'h00, 1'b0});
      wait_valid_a();
      in_op1 = 64'h4000_0000_0000_0000; in_op2 = 64'h4000_0000_0000_0000;
      in_OvEn = 1'b0; in_UnEn = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk("bp_result", out_result, 64'h4008_0000_0000_0000);
         chk("bp_valid_ready", 64'({out_valid, in_ready}), 64'b10);
         chk("bp_ops", op1 ^ op2, 64'h7FF0_0000_0000_0000);
         chk("bp_en", 64'({OvEn, UnEn}), 64'b11);
         @(negedge clk);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      qa.push_back('{64'h4010_0000_0000_0000, 5'h00, 1'b0});
      #1 in_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk("bp_gap_valid", 64'(out_valid), 64'(k == 3));
      end
      @(posedge clk); #1;

      // Sticky flags
      issue_a(64'h3FF0_0000_0000_0000, 64'h3C30_0000_0000_0000, 2'b00,
              '{64'h3FF0_0000_0000_0000, 5'h01, 1'b0});
      wait_valid_a();
      chk("sticky_set", 64'(acc_flags), 64'h01);
      @(posedge clk); #1;
      issue_a(64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 2'b00,
              '{64'h4000_0000_0000_0000, 5'h00, 1'b0});
      wait_valid_a();
      chk("sticky_keep", 64'(acc_flags), 64'h01);
      @(posedge clk); #1;

      // Clear colliding with capture: inf + -inf
      issue_a(64'h7FF0_0000_0000_0000, 64'hFFF0_0000_0000_0000, 2'b00,
              '{64'h7FF8_0000_0000_0000, 5'h10, 1'b0});
      @(posedge clk);
      #1 flag_clr = 1'b1;
      @(posedge clk);
      #1 flag_clr = 1'b0;
      @(negedge clk);
      chk("clr_collide_acc", 64'(acc_flags), 64'h10);
      chk("clr_collide_valid", 64'(out_valid), 64'd1);
      @(posedge clk);
      #1 flag_clr = 1'b1;
      @(posedge clk);
      #1 flag_clr = 1'b0;
      @(negedge clk);
      chk("clr_alone_acc", 64'(acc_flags), 64'h00);

      // Denormal operands
      @(posedge clk); #1;
      issue_a(64'h0008_0000_0000_0000, 64'h0008_0000_0000_0000, 2'b00,
              '{64'h0010_0000_0000_0000, 5'h00, 1'b1});
      wait_valid_a();
      chk("denorm_out", 64'(out_denorm), 64'd1);
      @(posedge clk); #1;

      // Reset during EXEC aborts the operation
      issue_a(64'h3FE0_0000_0000_0000, 64'h3FE0_0000_0000_0000, 2'b00,
              '{64'h3FF0_0000_0000_0000, 5'h00, 1'b0});
      void'(qa.pop_back());
      reset_n = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("abort_no_valid", 64'({out_valid, busy}), 64'd0);
      end
      chk("abort_ops_cleared", op1, 64'd0);
      chk("a_queue_empty", 64'(qa.size()), 64'd0);

      // Streaming on the HOLD_CYCLES=1 instance
      vb_a = '{64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000,
               64'h3FE0_0000_0000_0000, 64'h4010_0000_0000_0000, 64'h4008_0000_0000_0000,
               64'h3FF0_0000_0000_0000, 64'h3FF8_0000_0000_0000};
      vb_b = '{64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000,
               64'h3FE0_0000_0000_0000, 64'h4010_0000_0000_0000, 64'h3FF0_0000_0000_0000,
               64'hBFF0_0000_0000_0000, 64'h3FE0_0000_0000_0000};
      vb_r = '{64'h4000_0000_0000_0000, 64'h4010_0000_0000_0000, 64'h4008_0000_0000_0000,
               64'h3FF0_0000_0000_0000, 64'h4020_0000_0000_0000, 64'h4010_0000_0000_0000,
               64'h0000_0000_0000_0000, 64'h4000_0000_0000_0000};
      @(posedge clk); #1;
      begin
         int unsigned i = 0;
         int unsigned n = 0;
         bit acc;
         s_in_valid = 1'b1;
         while (i < 8 && n < 100) begin
            s_in_op1 = vb_a[i];
            s_in_op2 = vb_b[i];
            @(negedge clk);
            acc = s_in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
               qb.push_back('{vb_r[i], 5'h00, 1'b0});
               i++;
            end
            n++;
         end
         s_in_valid = 1'b0;
         chk("b_all_issued", 64'(i), 64'd8);
      end
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("b_result_count", 64'(nb), 64'd8);
      chk("b_queue_empty", 64'(qb.size()), 64'd0);
      chk("b_idle_state", 64'({s_busy, s_acc_flags, s_rm, s_op_type, s_P, s_OvEn, s_UnEn,
                               s_out_flags, s_out_denorm}), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/fpadd_issue.md
# fpadd_issue

Sequencing stage wrapped around the combinational floating-point adder/subtractor (`fpadd`). It accepts one operation per valid/ready handshake and registers its operands. It holds those operands stable on the adder inputs for a fixed multicycle window, then captures `AS_Result`/`Flags`/`Denorm` into an output register presented on a second valid/ready handshake. It also keeps a sticky, software-clearable accumulation of the IEEE exception flags.

## Interface
- `HOLD_CYCLES`, default 2: cycles the adder inputs are held before result capture; legal range 1..15.

- `clk` in 1: clock, rising edge.
- `reset_n` in 1: synchronous reset, active low.
- `in_valid` in 1: upstream operation valid.
- `in_ready` out 1: stage can accept an operation.
- `in_op1`, `in_op2` in 64 each: operands A and B.
- `in_rm` in 3: rounding mode.
- `in_op_type` in 3: function opcode.
- `in_P` in 2: precision; 00 double, 01 single, 11 half.
- `in_OvEn`, `in_UnEn` in 1 each: overflow and underflow trap enables.
- `op1`, `op2` out 64 each: registered operands driven to the adder.
- `rm`, `op_type`, `P`, `OvEn`, `UnEn` out 3/3/2/1/1: registered controls driven to the adder.
- `AS_Result` in 64, `Flags` in 5, `Denorm` in 1: adder outputs.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_result` out 64, `out_flags` out 5, `out_denorm` out 1: captured result.
- `acc_flags` out 5: sticky OR of `out_flags` since the last clear.
- `flag_clr` in 1: clears `acc_flags`.
- `busy` out 1: high in EXEC or DONE.

## Operation
- The FSM has three states: IDLE, EXEC, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: load all operand/control registers, load `cnt`=HOLD_CYCLES-1, go to EXEC.
- **EXEC**
  - `in_ready`=0 and the operand registers are frozen.
  - If `cnt`≠0, decrement `cnt`.
  - If `cnt`=0:
    - capture `AS_Result`/`Flags`/`Denorm` into the `out_*` registers;
    - set `out_valid`;
    - update `acc_flags`;
    - go to DONE.
- **DONE**
  - `out_valid`=1; the `out_*` registers and the operand registers are held.
  - `in_ready`=`out_ready`, combinational.
  - `out_ready`=1 and `in_valid`=1: load the new operation, reload `cnt`, go to EXEC. `out_valid` drops the next cycle.
  - `out_ready`=1 and `in_valid`=0: go to IDLE.
  - `out_ready`=0: stay in DONE.
- Operand registers change only on an accepted input handshake. The adder inputs are therefore stable from the cycle after acceptance until the next acceptance.
- `acc_flags` update rules:
  - on capture: `acc_flags` |= `Flags`;
  - `flag_clr` alone: `acc_flags`=0;
  - `flag_clr` in the same cycle as a capture: `acc_flags`=`Flags`, i.e. clear takes effect first and the new flags are kept.
- `cnt` is 4 bits wide. Out-of-range HOLD_CYCLES values are not supported. Implementation may add an elaboration check.

## Timing
- Reset (`reset_n`=0 sampled at a clock edge): state=IDLE, `cnt`=0, and every register output is 0. This covers `op1`, `op2`, `rm`, `op_type`, `P`, `OvEn`, `UnEn`, `out_result`, `out_flags`, `out_denorm`, `out_valid`, `acc_flags`.
  - `busy`=0; `in_ready`=1 from the first cycle after reset.
  - Reset mid-EXEC or mid-DONE aborts the operation with no output.
- Input handshake in cycle t:
  - adder inputs carry the new operands from cycle t+1;
  - EXEC occupies cycles t+1 .. t+HOLD_CYCLES;
  - `out_valid`=1 from cycle t+HOLD_CYCLES+1.
- Latency is HOLD_CYCLES+1. Peak throughput is one operation per HOLD_CYCLES+1 cycles with `out_ready` tied high.
- `out_valid` and `out_*` are register outputs. `in_ready` depends combinationally on state and `out_ready` only, never on `in_valid`.
- The adder is a multicycle path of HOLD_CYCLES cycles from the operand registers to the `out_*` registers.

## Test plan
- **Reset:** hold `reset_n`=0 for 2 cycles with `in_valid`=1 → all outputs 0, `in_ready`=1, no capture.
- **Latency, HOLD_CYCLES=2, real `fpadd` attached:**
  - stimulus: `in_op1`=`in_op2`=0x3FF0000000000000, `in_op_type`=000, `in_P`=00, `in_rm`=000, handshake in cycle 5;
  - required: `out_valid` rises in cycle 8, `out_result`=0x4000000000000000, `out_flags`=0, `busy` high in cycles 6–8.
- **Backpressure:**
  - stimulus: `out_ready`=0 for 10 cycles after `out_valid`;
  - required: `out_result` stable, `in_ready`=0, adder inputs unchanged;
  - then `out_ready`=1 with `in_valid`=1 → new operation accepted in the same cycle; `out_valid` low for exactly HOLD_CYCLES cycles.
- **Sticky flags:**
  - stimulus: `in_op1`=0x3FF0000000000000, `in_op2`=0x3C30000000000000 (1.0+2^-60) → `out_flags`≠0;
  - required: `acc_flags`=`out_flags`, and it persists across a following exact 1.0+1.0 operation.
- **Clear collision:** assert `flag_clr` in the EXEC cycle where `cnt`=0 → `acc_flags` equals that operation's `Flags` only.
- **HOLD_CYCLES=1, streaming:** `out_ready`=1 and 8 back-to-back operations → one result every 2 cycles, in order, with no drops or duplicates.
